// File: rtl/snake_pkg.sv
// snake_pkg: shared snake geometry, body segment type and apple spawn states
package snake_pkg;
  localparam int MAX_LEN = 50;
  localparam int DEF_GRID_W = 14;
  localparam int DEF_GRID_H = 14;
  localparam int DEF_MAX_TRIES = 8;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } seg_t;
  typedef enum logic [2:0] {INIT, IDLE, SAMPLE, SCAN, STEP, COMMIT} spawn_state_e;
endpackage

// File: rtl/apple_spawn_ctrl_seg_match.sv
// seg_match: candidate cell vs one body segment, plus playfield bounds check
module seg_match #(
  parameter int GRID_W = snake_pkg::DEF_GRID_W,
  parameter int GRID_H = snake_pkg::DEF_GRID_H
)(
  input  logic [7:0] cand,
  input  logic [7:0] seg,
  input  logic       seg_en,
  output logic       off,
  output logic       hit
);
  import snake_pkg::*;
  seg_t c;
  assign c = cand;
  assign off = c.x >= 4'(GRID_W) || c.y >= 4'(GRID_H);
  assign hit = off || (seg_en && cand == seg);
endmodule

// File: rtl/apple_spawn_ctrl.sv
// apple_spawn_ctrl: picks a free on-grid cell for the next apple and commits it
module apple_spawn_ctrl #(
  parameter int GRID_W    = snake_pkg::DEF_GRID_W,
  parameter int GRID_H    = snake_pkg::DEF_GRID_H,
  parameter int MAX_LEN   = snake_pkg::MAX_LEN,
  parameter int MAX_TRIES = snake_pkg::DEF_MAX_TRIES
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_reset,
  input  logic                 goodColl,
  input  logic [3:0]           randX,
  input  logic [3:0]           randY,
  input  logic [MAX_LEN*8-1:0] body,
  input  logic [5:0]           body_len,
  output logic [3:0]           apple_x,
  output logic [3:0]           apple_y,
  output logic                 apple_vld,
  output logic                 busy,
  output logic                 done,
  output logic                 board_full
);
  import snake_pkg::*;
  spawn_state_e state, state_n;
  seg_t cand, cand_n, seg, step_c;
  logic [5:0] idx, idx_n;
  logic [3:0] tries, tries_n, sx, sy;
  logic [7:0] sweep_cnt, sweep_n;
  logic pending, pending_n, vld_n, full_n, commit, hit, off, last, wrap_y;

  assign seg = (idx < 6'(MAX_LEN)) ? body[{idx, 3'b000} +: 8] : '0;
  assign last = body_len == 6'd0 || idx == body_len - 6'd1;
  assign busy = !(state == INIT || state == IDLE);

  seg_match #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_match (
    .cand(cand), .seg(seg), .seg_en(body_len != 6'd0), .off(off), .hit(hit)
  );

  // sweep walks rows within a column; an off-grid start jumps straight to the next column
  assign sy = cand.y + 4'd1;
  assign sx = cand.x + 4'd1;
  assign wrap_y = off || sy >= 4'(GRID_H);
  assign step_c.y = wrap_y ? 4'd0 : sy;
  assign step_c.x = wrap_y ? ((sx >= 4'(GRID_W)) ? 4'd0 : sx) : cand.x;

  always_comb begin
    state_n = state;
    cand_n = cand;
    idx_n = idx;
    tries_n = tries;
    sweep_n = sweep_cnt;
    pending_n = pending;
    vld_n = apple_vld;
    full_n = board_full;
    commit = 1'b0;
    case (state)
      INIT: state_n = SAMPLE;
      IDLE: if (goodColl) begin
        state_n = SAMPLE;
        vld_n = 1'b0;
      end
      SAMPLE: begin
        cand_n = {randX, randY};
        idx_n = 6'd0;
        tries_n = (tries == 4'hf) ? tries : tries + 4'd1;
        state_n = SCAN;
      end
      SCAN: if (hit) state_n = (tries < 4'(MAX_TRIES)) ? SAMPLE : STEP;
        else if (last) begin
          state_n = COMMIT;
          commit = 1'b1;
          vld_n = 1'b1;
        end else idx_n = idx + 6'd1;
      STEP: if (sweep_cnt == 8'(GRID_W * GRID_H)) begin
        state_n = IDLE;
        full_n = 1'b1;
        vld_n = 1'b0;
        tries_n = 4'd0;
        sweep_n = 8'd0;
      end else begin
        cand_n = step_c;
        idx_n = 6'd0;
        sweep_n = sweep_cnt + 8'd1;
        state_n = SCAN;
      end
      COMMIT: begin
        tries_n = 4'd0;
        sweep_n = 8'd0;
        pending_n = 1'b0;
        state_n = (pending || goodColl) ? SAMPLE : IDLE;
        vld_n = !(pending || goodColl);
      end
      default: state_n = INIT;
    endcase
    if (busy && goodColl && state != COMMIT) pending_n = 1'b1;
    if (s_reset) begin
      state_n = SAMPLE;
      vld_n = 1'b0;
      full_n = 1'b0;
      pending_n = 1'b0;
      tries_n = 4'd0;
      sweep_n = 8'd0;
      commit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cand <= '0;
      idx <= 6'd0;
      tries <= 4'd0;
      sweep_cnt <= 8'd0;
      pending <= 1'b0;
      apple_x <= 4'd0;
      apple_y <= 4'd0;
      apple_vld <= 1'b0;
      done <= 1'b0;
      board_full <= 1'b0;
    end else begin
      state <= state_n;
      cand <= cand_n;
      idx <= idx_n;
      tries <= tries_n;
      sweep_cnt <= sweep_n;
      pending <= pending_n;
      apple_vld <= vld_n;
      board_full <= full_n;
      done <= commit;
      if (commit) {apple_x, apple_y} <= cand;
    end
  end
endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// tb_apple_spawn_ctrl: directed checks of apple placement, retries, sweep and restarts
module tb_apple_spawn_ctrl;
  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic reset, s_reset, goodColl, apple_vld, busy, done, board_full;
  logic [3:0] randX, randY, apple_x, apple_y;
  logic [399:0] body;
  logic [5:0] body_len;

  logic reset2, s_reset2, goodColl2, apple_vld2, busy2, done2, board_full2;
  logic [3:0] randX2, randY2, apple_x2, apple_y2;
  logic [399:0] body2;
  logic [5:0] body_len2;

  int checks = 0;
  int failures = 0;

  apple_spawn_ctrl dut (
    .clk(tb_clk), .reset(reset), .s_reset(s_reset), .goodColl(goodColl),
    .randX(randX), .randY(randY), .body(body), .body_len(body_len),
    .apple_x(apple_x), .apple_y(apple_y), .apple_vld(apple_vld),
    .busy(busy), .done(done), .board_full(board_full)
  );

  apple_spawn_ctrl #(.GRID_W(2), .GRID_H(2)) dut2 (
    .clk(tb_clk), .reset(reset2), .s_reset(s_reset2), .goodColl(goodColl2),
    .randX(randX2), .randY(randY2), .body(body2), .body_len(body_len2),
    .apple_x(apple_x2), .apple_y(apple_y2), .apple_vld(apple_vld2),
    .busy(busy2), .done(done2), .board_full(board_full2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; s_reset = 1'b0; goodColl = 1'b0;
    randX = 4'd5; randY = 4'd8;
    body = '0; body[31:0] = {8'h45, 8'h46, 8'h47, 8'h47}; body_len = 6'd4;
    step(2);
    checks += 5;
    if (apple_vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", apple_vld); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if ({apple_x, apple_y} !== 8'h00) begin failures++; $display("FAIL rst_xy got=%h exp=00", {apple_x, apple_y}); end
    if (board_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", board_full); end
    reset = 1'b1;
    step(6);
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL first_done got=%b exp=1", done); end
    if ({apple_x, apple_y} !== 8'h58) begin failures++; $display("FAIL first_xy got=%h exp=58", {apple_x, apple_y}); end
    if (apple_vld !== 1'b1) begin failures++; $display("FAIL first_vld got=%b exp=1", apple_vld); end
    if (busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%b exp=1", busy); end
    step(1);
    checks += 3;
    if (done !== 1'b0) begin failures++; $display("FAIL first_done_pulse got=%b exp=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL first_idle got=%b exp=0", busy); end
    if (apple_vld !== 1'b1) begin failures++; $display("FAIL first_vld_hold got=%b exp=1", apple_vld); end
  endtask

  task automatic test_occupied;
    int n;
    step(2);
    randX = 4'd4; randY = 4'd7; goodColl = 1'b1;
    step(1);
    goodColl = 1'b0;
    checks += 2;
    if (apple_vld !== 1'b0) begin failures++; $display("FAIL occ_vld_clear got=%b exp=0", apple_vld); end
    if (busy !== 1'b1) begin failures++; $display("FAIL occ_busy got=%b exp=1", busy); end
    step(1);
    randX = 4'd6; randY = 4'd2;
    wait_done(n);
    checks += 2;
    if (n !== 6) begin failures++; $display("FAIL occ_latency got=%0d exp=6", n); end
    if ({apple_x, apple_y} !== 8'h62) begin failures++; $display("FAIL occ_xy got=%h exp=62", {apple_x, apple_y}); end
  endtask

  task automatic test_offgrid;
    int n;
    step(2);
    randX = 4'd15; randY = 4'd3; body_len = 6'd0; goodColl = 1'b1;
    step(1);
    goodColl = 1'b0;
    wait_done(n);
    checks += 3;
    if (n !== 18) begin failures++; $display("FAIL off_latency got=%0d exp=18", n); end
    if ({apple_x, apple_y} !== 8'h00) begin failures++; $display("FAIL off_xy got=%h exp=00", {apple_x, apple_y}); end
    if (apple_vld !== 1'b1) begin failures++; $display("FAIL off_vld got=%b exp=1", apple_vld); end
  endtask

  task automatic test_back_to_back;
    int cnt, first, second;
    step(2);
    randX = 4'd5; randY = 4'd8; body_len = 6'd4; goodColl = 1'b1;
    step(1);
    goodColl = 1'b0;
    step(1);
    goodColl = 1'b1;
    step(1);
    goodColl = 1'b0;
    cnt = 0; first = -1; second = -1;
    for (int i = 3; i <= 20; i++) begin
      step(1);
      if (done) begin
        cnt++;
        if (cnt == 1) first = i; else second = i;
      end
    end
    checks += 3;
    if (cnt !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", cnt); end
    if (first !== 5) begin failures++; $display("FAIL b2b_first got=%0d exp=5", first); end
    if (second !== 11) begin failures++; $display("FAIL b2b_second got=%0d exp=11", second); end
  endtask

  task automatic test_sreset;
    int cnt, first, n;
    step(2);
    goodColl = 1'b1;
    step(1);
    goodColl = 1'b0;
    step(1);
    s_reset = 1'b1; goodColl = 1'b1;
    step(1);
    s_reset = 1'b0; goodColl = 1'b0;
    checks += 2;
    if (apple_vld !== 1'b0) begin failures++; $display("FAIL srst_vld got=%b exp=0", apple_vld); end
    if (busy !== 1'b1) begin failures++; $display("FAIL srst_busy got=%b exp=1", busy); end
    cnt = 0; first = -1;
    for (int i = 3; i <= 25; i++) begin
      step(1);
      if (done) begin
        cnt++;
        if (cnt == 1) first = i;
      end
    end
    checks += 2;
    if (cnt !== 1) begin failures++; $display("FAIL srst_count got=%0d exp=1", cnt); end
    if (first !== 7) begin failures++; $display("FAIL srst_first got=%0d exp=7", first); end
    s_reset = 1'b1;
    step(1);
    s_reset = 1'b0;
    checks += 2;
    if (apple_vld !== 1'b0) begin failures++; $display("FAIL srst_idle_vld got=%b exp=0", apple_vld); end
    if (busy !== 1'b1) begin failures++; $display("FAIL srst_idle_busy got=%b exp=1", busy); end
    wait_done(n);
    checks += 1;
    if (n !== 5) begin failures++; $display("FAIL srst_idle_latency got=%0d exp=5", n); end
  endtask

  task automatic test_board_full;
    int n;
    reset2 = 1'b0; s_reset2 = 1'b0; goodColl2 = 1'b0;
    randX2 = 4'd0; randY2 = 4'd0;
    body2 = '0; body2[31:0] = {8'h11, 8'h10, 8'h01, 8'h00}; body_len2 = 6'd4;
    step(1);
    reset2 = 1'b1;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step(1);
      if (board_full2) begin
        n = i;
        break;
      end
    end
    checks += 4;
    if (n !== 32) begin failures++; $display("FAIL full_latency got=%0d exp=32", n); end
    if (apple_vld2 !== 1'b0) begin failures++; $display("FAIL full_vld got=%b exp=0", apple_vld2); end
    if (busy2 !== 1'b0) begin failures++; $display("FAIL full_idle got=%b exp=0", busy2); end
    if (done2 !== 1'b0) begin failures++; $display("FAIL full_done got=%b exp=0", done2); end
    s_reset2 = 1'b1;
    step(1);
    s_reset2 = 1'b0;
    checks += 2;
    if (board_full2 !== 1'b0) begin failures++; $display("FAIL full_clear got=%b exp=0", board_full2); end
    if (busy2 !== 1'b1) begin failures++; $display("FAIL full_restart got=%b exp=1", busy2); end
  endtask

  task automatic test_async_reset;
    step(2);
    randX = 4'd5; randY = 4'd8; goodColl = 1'b1;
    step(1);
    goodColl = 1'b0;
    step(2);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if ({apple_x, apple_y} !== 8'h00) begin failures++; $display("FAIL arst_xy got=%h exp=00", {apple_x, apple_y}); end
    if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    if (apple_vld !== 1'b0) begin failures++; $display("FAIL arst_vld got=%b exp=0", apple_vld); end
    if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", done); end
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    reset2 = 1'b0; s_reset2 = 1'b0; goodColl2 = 1'b0;
    randX2 = 4'd0; randY2 = 4'd0; body2 = '0; body_len2 = 6'd0;
    test_reset;
    test_occupied;
    test_offgrid;
    test_back_to_back;
    test_sreset;
    test_board_full;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
